nes_cpu_bus_responder: RTL and testbench

- Responder end of the NES CPU bus: decodes CPU address and read/write, returns read data, and commits writes and read side effects.
- Owns the 2 KB internal work RAM (mirrored) and both standard-controller shift registers at $4016/$4017.
- Passes PPU-register ($2000-$3FFF) and PRG ROM ($8000-$FFFF) accesses through to external blocks.
- Drives open-bus values for unmapped reads.

---
 rtl/nes_cpu_bus_responder.sv | 143 ++++++++++++++
 tb/tb_nes_cpu_bus_responder.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/nes_cpu_bus_responder.sv
// rtl/nes_cpu_bus_responder.sv - NES CPU bus responder: work RAM, joypads, PPU/PRG pass-through, open bus
//
// Purpose:
//   Decodes the CPU address/rw, returns read data combinationally and commits
//   writes and read side effects once per CPU access, on the rising clock edge
//   where busPhase=1.
//
// Ports:
//   clock, reset        system clock, asynchronous active-high reset
//   busPhase            1 on the edge where the CPU samples readData (commit edge)
//   address, rw         CPU address bus, 1=read / 0=write
//   writeData           CPU write data
//   readData            combinational read data to the CPU
//   pad1Buttons/pad2Buttons  live controller states (bit0=A ... bit7=Right)
//   joyStrobe           current $4016 bit0 latch
//   ppuSelect, ppuReg   PPU window decode and register index
//   ppuWrite, ppuRead   one-clock pulses after a PPU write/read commit
//   ppuData             PPU register read data
//   prgAddress, prgData PRG ROM window address and data

`timescale 1ns/1ps

module nes_cpu_bus_responder #(
   parameter int RAM_ADDR_BITS = 11,
   parameter int PRG_ADDR_BITS = 15
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     busPhase,
   input  logic [15:0]              address,
   input  logic [7:0]               writeData,
   input  logic                     rw,
   output logic [7:0]               readData,
   input  logic [7:0]               pad1Buttons,
   input  logic [7:0]               pad2Buttons,
   output logic                     joyStrobe,
   output logic                     ppuSelect,
   output logic [2:0]               ppuReg,
   output logic                     ppuWrite,
   output logic                     ppuRead,
   input  logic [7:0]               ppuData,
   output logic [PRG_ADDR_BITS-1:0] prgAddress,
   input  logic [7:0]               prgData
);

   localparam int RAM_DEPTH = 1 << RAM_ADDR_BITS;

   logic [7:0] r_ram [RAM_DEPTH];
   logic [7:0] r_shift1;
   logic [7:0] r_shift2;
   logic [7:0] r_open_bus;
   logic       r_joy_strobe;
   logic       r_ppu_write;
   logic       r_ppu_read;

   logic       w_is_ram;
   logic       w_is_ppu;
   logic       w_is_joy1;
   logic       w_is_joy2;
   logic       w_is_prg;
   logic       w_wr_commit;
   logic       w_rd_commit;
   logic [7:0] w_read_data;
   logic [RAM_ADDR_BITS-1:0] w_ram_index;

   // Address decode; the RAM index is a plain truncation, which gives the
   // four-way mirror across $0000-$1FFF.
   assign w_is_ram    = (address[15:13] == 3'b000);
   assign w_is_ppu    = (address[15:13] == 3'b001);
   assign w_is_joy1   = (address == 16'h4016);
   assign w_is_joy2   = (address == 16'h4017);
   assign w_is_prg    = address[15];
   assign w_ram_index = address[RAM_ADDR_BITS-1:0];

   // The CPU holds each access for two clocks; only the busPhase edge commits.
   assign w_wr_commit = busPhase & ~rw;
   assign w_rd_commit = busPhase &  rw;

   always_comb begin
      w_read_data = r_open_bus;
      if (w_is_ram)
         w_read_data = r_ram[w_ram_index];
      else if (w_is_ppu)
         w_read_data = ppuData;
      else if (w_is_joy1)
         w_read_data = {r_open_bus[7:5], 4'b0000, r_shift1[0]};
      else if (w_is_joy2)
         w_read_data = {r_open_bus[7:5], 4'b0000, r_shift2[0]};
      else if (w_is_prg)
         w_read_data = prgData;
   end

   // Work RAM has no reset; the write enable is still gated so a commit that
   // coincides with reset is abandoned.
   always_ff @(posedge clock) begin
      if (w_wr_commit && w_is_ram && !reset)
         r_ram[w_ram_index] <= writeData;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_joy_strobe <= 1'b0;
         r_shift1     <= 8'h00;
         r_shift2     <= 8'h00;
         r_open_bus   <= 8'h00;
         r_ppu_write  <= 1'b0;
         r_ppu_read   <= 1'b0;
      end else begin
         r_ppu_write <= w_wr_commit & w_is_ppu;
         r_ppu_read  <= w_rd_commit & w_is_ppu;

         if (w_wr_commit)
            r_open_bus <= writeData;
         else if (w_rd_commit)
            r_open_bus <= w_read_data;

         if (w_wr_commit && w_is_joy1)
            r_joy_strobe <= writeData[0];

         // While the strobe is high the shifters track the pads every clock;
         // the reload also overrides any shift from a concurrent read. Ones
         // shift in from the top so reads past the eighth return 1.
         if (r_joy_strobe) begin
            r_shift1 <= pad1Buttons;
            r_shift2 <= pad2Buttons;
         end else begin
            if (w_rd_commit && w_is_joy1)
               r_shift1 <= {1'b1, r_shift1[7:1]};
            if (w_rd_commit && w_is_joy2)
               r_shift2 <= {1'b1, r_shift2[7:1]};
         end
      end
   end

   assign readData   = w_read_data;
   assign joyStrobe  = r_joy_strobe;
   assign ppuSelect  = w_is_ppu;
   assign ppuReg     = address[2:0];
   assign ppuWrite   = r_ppu_write;
   assign ppuRead    = r_ppu_read;
   assign prgAddress = address[PRG_ADDR_BITS-1:0];

endmodule

// File: tb/tb_nes_cpu_bus_responder.sv
// tb/tb_nes_cpu_bus_responder.sv - self-checking bench for nes_cpu_bus_responder

`timescale 1ns/1ps

module tb_nes_cpu_bus_responder;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        busPhase = 1'b0;
   logic [15:0] address = 16'h0000;
   logic [7:0]  writeData = 8'h00;
   logic        rw = 1'b1;
   logic [7:0]  readData;
   logic [7:0]  pad1Buttons = 8'h00;
   logic [7:0]  pad2Buttons = 8'h00;
   logic        joyStrobe;
   logic        ppuSelect;
   logic [2:0]  ppuReg;
   logic        ppuWrite;
   logic        ppuRead;
   logic [7:0]  ppuData = 8'h00;
   logic [14:0] prgAddress;
   logic [7:0]  prgData = 8'h00;

   nes_cpu_bus_responder #(.RAM_ADDR_BITS(11), .PRG_ADDR_BITS(15)) dut (
      .clock(clock), .reset(reset), .busPhase(busPhase), .address(address),
      .writeData(writeData), .rw(rw), .readData(readData),
      .pad1Buttons(pad1Buttons), .pad2Buttons(pad2Buttons), .joyStrobe(joyStrobe),
      .ppuSelect(ppuSelect), .ppuReg(ppuReg), .ppuWrite(ppuWrite), .ppuRead(ppuRead),
      .ppuData(ppuData), .prgAddress(prgAddress), .prgData(prgData)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference model: memory contents, the open-bus byte, the strobe, and for
   // each pad the frame latched at the strobe's fall plus a count of reads since.
   logic [7:0] m_ram [2048];
   bit         m_written [2048];
   logic [7:0] m_open = 8'h00;
   bit         m_strobe = 1'b0;
   logic [7:0] m_latch1 = 8'h00;
   logic [7:0] m_latch2 = 8'h00;
   int         m_idx1 = 0;
   int         m_idx2 = 0;

   function automatic logic pad_bit(input logic [7:0] live, input logic [7:0] latch, input int idx);
      if (m_strobe) return live[0];
      return (idx < 8) ? latch[idx] : 1'b1;
   endfunction

   function automatic logic [7:0] model_read(input logic [15:0] a);
      if (a < 16'h2000)       return m_ram[a[10:0]];
      else if (a < 16'h4000)  return ppuData;
      else if (a == 16'h4016) return {m_open[7:5], 4'b0000, pad_bit(pad1Buttons, m_latch1, m_idx1)};
      else if (a == 16'h4017) return {m_open[7:5], 4'b0000, pad_bit(pad2Buttons, m_latch2, m_idx2)};
      else if (a >= 16'h8000) return prgData;
      return m_open;
   endfunction

   // One CPU access: a non-commit clock followed by the commit clock.
   task automatic do_op(input logic [15:0] a, input bit rd, input logic [7:0] wd, output logic [7:0] got);
      logic [7:0] exp;
      bit         is_ppu;
      @(negedge clock);
      address = a; rw = rd; writeData = wd; busPhase = 1'b0;
      ppuData = 8'($urandom); prgData = 8'($urandom);
      @(posedge clock); #1;
      check("ppuWrite_idle", ppuWrite, 0);
      check("ppuRead_idle", ppuRead, 0);
      @(negedge clock);
      busPhase = 1'b1;
      #1;
      exp = model_read(a);
      got = readData;
      is_ppu = (a >= 16'h2000) && (a < 16'h4000);
      if (rd) check("readData", got, exp);
      check("ppuSelect", ppuSelect, is_ppu);
      check("ppuReg", ppuReg, a[2:0]);
      check("prgAddress", prgAddress, a[14:0]);
      @(posedge clock); #1;
      check("ppuWrite_commit", ppuWrite, is_ppu && !rd);
      check("ppuRead_commit", ppuRead, is_ppu && rd);
      if (rd) begin
         m_open = exp;
         if (!m_strobe && a == 16'h4016 && m_idx1 < 8) m_idx1++;
         if (!m_strobe && a == 16'h4017 && m_idx2 < 8) m_idx2++;
      end else begin
         m_open = wd;
         if (a < 16'h2000) begin
            m_ram[a[10:0]] = wd;
            m_written[a[10:0]] = 1'b1;
         end
         if (a == 16'h4016) begin
            if (m_strobe && !wd[0]) begin
               m_latch1 = pad1Buttons; m_latch2 = pad2Buttons;
               m_idx1 = 0; m_idx2 = 0;
            end
            m_strobe = wd[0];
         end
      end
      check("joyStrobe", joyStrobe, m_strobe);
   endtask

   logic [7:0] got;
   logic [9:0] seq;
   logic [15:0] ra;
   bit          rrd;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      // Reset state, observed through unmapped open bus and the outputs.
      address = 16'h5000;
      repeat (2) @(negedge clock);
      check("rst_joyStrobe", joyStrobe, 0);
      check("rst_ppuWrite", ppuWrite, 0);
      check("rst_ppuRead", ppuRead, 0);
      check("rst_openbus", readData, 8'h00);
      reset = 1'b0;

      // RAM mirroring.
      do_op(16'h0012, 0, 8'h55, got);
      do_op(16'h0812, 1, 8'h00, got); check("mirror_0812", got, 8'h55);
      do_op(16'h1012, 1, 8'h00, got); check("mirror_1012", got, 8'h55);
      do_op(16'h1812, 1, 8'h00, got); check("mirror_1812", got, 8'h55);
      do_op(16'h5000, 1, 8'h00, got); check("openbus_after_ram", got, 8'h55);

      // Controller serial read-out.
      pad1Buttons = 8'b1000_0101;
      do_op(16'h4016, 0, 8'h01, got);
      do_op(16'h4016, 0, 8'h00, got);
      do_op(16'h5000, 0, 8'h40, got);
      pad1Buttons = 8'h00;
      seq = 10'b11_1000_0101;
      for (int i = 0; i < 10; i++) begin
         do_op(16'h4016, 1, 8'h00, got);
         check("joy_seq", got, {7'b0100000, seq[i]});
      end

      // Strobe held high: every read returns A.
      pad1Buttons = 8'b1000_0101;
      do_op(16'h4016, 0, 8'h01, got);
      for (int i = 0; i < 3; i++) begin
         do_op(16'h4016, 1, 8'h00, got);
         check("strobe_hold_A", got[0], 1'b1);
      end
      do_op(16'h4016, 0, 8'h00, got);
      do_op(16'h4016, 1, 8'h00, got); check("after_hold_A", got[0], 1'b1);
      do_op(16'h4016, 1, 8'h00, got); check("after_hold_B", got[0], 1'b0);

      // PPU and PRG pass-through, write to ROM and unmapped open bus.
      do_op(16'h2006, 0, 8'h3F, got);
      do_op(16'h2002, 1, 8'h00, got);
      do_op(16'hFFFC, 1, 8'h00, got);
      do_op(16'h8000, 0, 8'h99, got);
      do_op(16'h8000, 1, 8'h00, got);
      do_op(16'h5000, 0, 8'hA7, got);
      do_op(16'h5000, 1, 8'h00, got); check("unmapped_A7", got, 8'hA7);

      // Randomized traffic against the model.
      for (int n = 0; n < 500; n++) begin
         case ($urandom_range(0, 5))
            0: ra = {3'b000, 2'($urandom_range(0, 3)), 7'd0, 4'($urandom_range(0, 15))};
            1: ra = 16'h2000 | 16'($urandom_range(0, 16'h1FFF));
            2: ra = 16'h4016;
            3: ra = 16'h4017;
            4: ra = 16'h8000 | 16'($urandom_range(0, 16'h7FFF));
            default: ra = 16'h5000 + 16'($urandom_range(0, 16'h0FFF));
         endcase
         rrd = 1'($urandom_range(0, 1));
         if (ra < 16'h2000 && rrd && !m_written[ra[10:0]]) rrd = 1'b0;
         if ($urandom_range(0, 3) == 0) begin
            pad1Buttons = 8'($urandom);
            pad2Buttons = 8'($urandom);
         end
         do_op(ra, rrd, 8'($urandom), got);
      end

      // Reset in the middle of a read access.
      do_op(16'h4016, 0, 8'h01, got);
      @(negedge clock);
      address = 16'h5000; rw = 1'b1; busPhase = 1'b0;
      @(posedge clock);
      @(negedge clock);
      busPhase = 1'b1;
      #1;
      check("pre_reset_openbus", readData, 8'h01);
      #1 reset = 1'b1;
      #1;
      check("mid_reset_openbus", readData, 8'h00);
      check("mid_reset_strobe", joyStrobe, 0);
      @(posedge clock); #1;
      check("reset_hold_openbus", readData, 8'h00);
      check("reset_hold_ppuRead", ppuRead, 0);
      @(negedge clock);
      reset = 1'b0; busPhase = 1'b0;
      m_open = 8'h00; m_strobe = 1'b0;
      m_latch1 = 8'h00; m_latch2 = 8'h00; m_idx1 = 0; m_idx2 = 0;

      // Shifters were cleared: zeros then ones.
      for (int i = 0; i < 10; i++) begin
         do_op(16'h4017, 1, 8'h00, got);
         check("post_reset_joy2", got[0], (i >= 8));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
